simon_verify_input: RTL and testbench

- Checks the player's button presses against the stored Simon Says colour sequence for the current round.
- Sits between the game FSM, which supplies the round index and enable over the fsm_sig signal group, and the debounced button inputs.
- Round N requires the player to reproduce sequence entries 0..N in order.
- Reports pass or fail to the FSM.

---
 rtl/simon_pkg.sv | 35 +++
 rtl/fsm_sig.sv | 10 +
 rtl/simon_press_detect.sv | 47 ++++
 rtl/simon_verify_input.sv | 104 ++++++++++
 tb/tb_simon_verify_input.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared constants, types and helpers for the Simon Says input verifier.
package simon_pkg;
  localparam int SEQ_LEN = 33;
  localparam int COLOR_W = 2;
  localparam int BTN_W   = 4;
  localparam int ROUND_W = 6;

  typedef logic [COLOR_W-1:0] color_t;
  typedef color_t [SEQ_LEN-1:0] seq_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } verify_state_t;

  localparam logic [ROUND_W-1:0] LAST_POS = ROUND_W'(SEQ_LEN - 1);

  // Index of the highest set button; only meaningful when exactly one bit is set.
  function automatic color_t btn_to_color(input logic [BTN_W-1:0] btn);
    color_t c;
    c = {COLOR_W{1'b0}};
    for (int i = 0; i < BTN_W; i++) begin
      if (btn[i]) begin
        c = color_t'(i);
      end
    end
    return c;
  endfunction

  function automatic logic btn_multi(input logic [BTN_W-1:0] btn);
    return (btn & (btn - BTN_W'(1))) != {BTN_W{1'b0}};
  endfunction
endpackage

// File: rtl/fsm_sig.sv
// Handshake bundle between the game FSM and the input verifier.
interface fsm_sig;
  logic                         check_en;
  logic [simon_pkg::ROUND_W-1:0] check_round;
  logic                         round_pass;
  logic                         round_fail;

  modport fsm      (output check_en, check_round, input round_pass, round_fail);
  modport verifier (input check_en, check_round, output round_pass, round_fail);
endinterface

// File: rtl/simon_press_detect.sv
// Button press edge detector; VERIFY_INPUT_SYNC_EN adds a two-flop synchronizer in front.
module simon_press_detect
  import simon_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [BTN_W-1:0] player_input,
  output logic             press,
  output logic             multi_err,
  output color_t           color
);
  logic [BTN_W-1:0] sampled_s;
  logic [BTN_W-1:0] prev_r;

`ifdef VERIFY_INPUT_SYNC_EN
  logic [BTN_W-1:0] sync1_r;
  logic [BTN_W-1:0] sync2_r;

  // Two-flop synchronizer for asynchronous button levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= {BTN_W{1'b0}};
      sync2_r <= {BTN_W{1'b0}};
    end else begin
      sync1_r <= player_input;
      sync2_r <= sync1_r;
    end
  end

  assign sampled_s = sync2_r;
`else
  assign sampled_s = player_input;
`endif

  // Previous button levels, so a held button never re-triggers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r <= {BTN_W{1'b0}};
    end else begin
      prev_r <= sampled_s;
    end
  end

  assign press     = (sampled_s != {BTN_W{1'b0}}) && (prev_r == {BTN_W{1'b0}});
  assign multi_err = btn_multi(sampled_s);
  assign color     = btn_to_color(sampled_s);
endmodule

// File: rtl/simon_verify_input.sv
// Compares player presses against the stored colour sequence for the current round.
// Optional input synchronizer: define VERIFY_INPUT_SYNC_EN.
module simon_verify_input
  import simon_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  seq_t               segment,
  input  logic [BTN_W-1:0]   player_input,
  input  logic               check_en,
  input  logic [ROUND_W-1:0] check_round,
  output logic               round_pass,
  output logic               round_fail,
  output logic [ROUND_W-1:0] position
);
  fsm_sig sig ();

  verify_state_t      state_r;
  logic [ROUND_W-1:0] position_r;
  logic [ROUND_W-1:0] round_r;
  logic               pass_r;
  logic               fail_r;
  logic               press_s;
  logic               multi_s;
  color_t             color_s;

  assign sig.check_en    = check_en;
  assign sig.check_round = check_round;
  assign sig.round_pass  = pass_r;
  assign sig.round_fail  = fail_r;
  assign round_pass      = sig.round_pass;
  assign round_fail      = sig.round_fail;
  assign position        = position_r;

  simon_press_detect u_press (
    .clk          (clk),
    .reset        (reset),
    .player_input (player_input),
    .press        (press_s),
    .multi_err    (multi_s),
    .color        (color_s)
  );

  // Round verification state machine; dropping check_en beats any press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      position_r <= {ROUND_W{1'b0}};
      round_r    <= {ROUND_W{1'b0}};
      pass_r     <= 1'b0;
      fail_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          pass_r     <= 1'b0;
          fail_r     <= 1'b0;
          position_r <= {ROUND_W{1'b0}};
          if (sig.check_en) begin
            round_r <= (sig.check_round > LAST_POS) ? LAST_POS : sig.check_round;
            state_r <= ARMED;
          end else begin
            state_r <= IDLE;
          end
        end
        ARMED: begin
          if (!sig.check_en) begin
            state_r    <= IDLE;
            position_r <= {ROUND_W{1'b0}};
            pass_r     <= 1'b0;
            fail_r     <= 1'b0;
          end else if (press_s) begin
            if (multi_s || (color_s != segment[position_r])) begin
              state_r <= FAIL;
              fail_r  <= 1'b1;
            end else if (position_r == round_r) begin
              state_r <= PASS;
              pass_r  <= 1'b1;
            end else begin
              position_r <= position_r + ROUND_W'(1);
            end
          end else begin
            state_r <= ARMED;
          end
        end
        PASS, FAIL: begin
          if (!sig.check_en) begin
            state_r    <= IDLE;
            position_r <= {ROUND_W{1'b0}};
            pass_r     <= 1'b0;
            fail_r     <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          position_r <= {ROUND_W{1'b0}};
          pass_r     <= 1'b0;
          fail_r     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_simon_verify_input.sv
// Scoreboard bench for simon_verify_input: directed plan plus randomized rounds.
module tb_simon_verify_input;
  import simon_pkg::*;

`ifdef VERIFY_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  seq_t         segment;
  logic [3:0]   player_input;
  logic         check_en;
  logic [5:0]   check_round;
  logic         round_pass;
  logic         round_fail;
  logic [5:0]   position;

  simon_verify_input dut (
    .clk          (clk),
    .reset        (reset),
    .segment      (segment),
    .player_input (player_input),
    .check_en     (check_en),
    .check_round  (check_round),
    .round_pass   (round_pass),
    .round_fail   (round_fail),
    .position     (position)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pass;
    logic fail;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: what the player has achieved so far this round.
  int m_seq[SEQ_LEN];
  int m_round;
  int m_k;
  bit m_active;
  bit m_done;
  bit m_pass;
  bit m_fail;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  logic prev_flag = 1'b0;
  always @(negedge clk) begin
    if ((round_pass || round_fail) && !prev_flag) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual pass=%0d fail=%0d required no flag", round_pass, round_fail);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_pass", int'(round_pass), int'(mon_e.pass));
        check("sb_fail", int'(round_fail), int'(mon_e.fail));
      end
    end
    if (round_pass && round_fail) begin
      checks++;
      errors++;
      $display("FAIL both_flags actual=1 required=0");
    end
    prev_flag = round_pass || round_fail;
  end

  task automatic load_seq(input bit rnd);
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (rnd) m_seq[i] = int'($urandom_range(0, 3));
      else     m_seq[i] = (i % 5 == 4) ? 0 : (i % 5);
      segment[i] = color_t'(m_seq[i]);
    end
  endtask

  task automatic model_start(input int n);
    m_active = 1'b1;
    m_round  = (n > SEQ_LEN - 1) ? SEQ_LEN - 1 : n;
    m_k      = 0;
    m_done   = 1'b0;
    m_pass   = 1'b0;
    m_fail   = 1'b0;
  endtask

  task automatic model_clear();
    m_active = 1'b0;
    m_k      = 0;
    m_done   = 1'b0;
    m_pass   = 1'b0;
    m_fail   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_pass"}, int'(round_pass), int'(m_pass));
    check({tag, "_fail"}, int'(round_fail), int'(m_fail));
    check({tag, "_pos"}, int'(position), m_k);
  endtask

  // All tasks begin and end just after a rising edge.
  task automatic start_round(input int n);
    check_en    = 1'b1;
    check_round = 6'(n);
    @(posedge clk); #1;
    model_start(n);
    @(negedge clk);
    check_outputs("start");
    @(posedge clk); #1;
  endtask

  task automatic end_round(input logic [3:0] v);
    check_en     = 1'b0;
    player_input = v;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    check_outputs("drop_en");
    @(posedge clk); #1;
    player_input = 4'b0000;
    repeat (LAT + 1) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] v, input int hold);
    int idx;
    player_input = v;
    if (m_active && !m_done) begin
      idx = 0;
      for (int b = 0; b < 4; b++) if (v[b]) idx = b;
      if ($countones(v) != 1 || idx != m_seq[m_k]) begin
        m_fail = 1'b1;
        m_done = 1'b1;
        exp_q.push_back('{pass: 1'b0, fail: 1'b1});
      end else if (m_k == m_round) begin
        m_pass = 1'b1;
        m_done = 1'b1;
        exp_q.push_back('{pass: 1'b1, fail: 1'b0});
      end else begin
        m_k++;
      end
    end
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    check_outputs("press");
    repeat (hold) @(posedge clk);
    #1;
    player_input = 4'b0000;
    repeat (LAT + 1) @(posedge clk);
    #1;
    check_outputs("release");
  endtask

  task automatic press_color(input int c);
    logic [3:0] v;
    v = 4'b0001 << c;
    press(v, 1);
  endtask

  task automatic reset_mid(input int new_round);
    reset       = 1'b1;
    check_round = 6'(new_round);
    @(posedge clk);
    model_clear();
    @(negedge clk);
    check_outputs("reset_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    model_start(new_round);
  endtask

  initial begin
    int n;
    int r;
    logic [3:0] v;
    reset        = 1'b1;
    check_en     = 1'b0;
    check_round  = 6'd0;
    player_input = 4'b0000;
    load_seq(1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Idle presses are ignored.
    press(4'b0001, 1);

    start_round(0);
    press(4'b0001, 1);
    end_round(4'b0000);

    start_round(3);
    press(4'b0001, 1);
    press(4'b0010, 1);
    press(4'b0100, 1);
    press(4'b1000, 1);
    end_round(4'b0000);

    start_round(2);
    press(4'b0001, 1);
    press(4'b0100, 1);
    press(4'b0010, 1);
    end_round(4'b0000);

    start_round(1);
    press(4'b0011, 1);
    end_round(4'b0000);
    start_round(1);
    press(4'b0001, 10);
    end_round(4'b0000);

    start_round(1);
    check_round = 6'd5;
    press(4'b0001, 1);
    press(4'b0010, 1);
    end_round(4'b0000);

    // Dropping check_en while a correct press arrives.
    start_round(0);
    end_round(4'b0001);

    start_round(4);
    press(4'b0001, 1);
    press(4'b0010, 1);
    reset_mid(0);
    press(4'b0001, 1);
    end_round(4'b0000);

    // Longest round, with an out-of-range round index that must clamp.
    start_round(63);
    for (int i = 0; i < SEQ_LEN; i++) press_color(m_seq[i]);
    press_color(m_seq[0]);
    end_round(4'b0000);

    for (int rr = 0; rr < 12; rr++) begin
      load_seq(1'b1);
      n = (rr == 0) ? SEQ_LEN - 1 : int'($urandom_range(0, 40));
      start_round(n);
      while (!m_done) begin
        r = int'($urandom_range(0, 99));
        if (r < 4 && rr != 0) begin
          v = 4'($urandom_range(0, 15));
          if ($countones(v) < 2) v = 4'b1010;
          press(v, int'($urandom_range(1, 3)));
        end else if (r < 8 && rr != 0) begin
          press_color((m_seq[m_k] + int'($urandom_range(1, 3))) % 4);
        end else begin
          press_color(m_seq[m_k]);
        end
      end
      press_color(int'($urandom_range(0, 3)));
      end_round(4'b0000);
    end

    repeat (4) @(posedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
